// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridging a command/response port onto an APB bus
//
// Purpose: accepts one read/write command at a time and runs it as an APB
// SETUP/ACCESS transfer. A completion pulse reports read data, or an error
// when the completer holds PREADY low for TIMEOUT ACCESS cycles.
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/cmd_addr/cmd_wdata command fields, latched on acceptance
//   rsp_valid                    one-cycle completion pulse
//   rsp_rdata/rsp_err            completion data / timeout flag, held until next completion
//   busy                         transfer in progress
//   PSEL/PENABLE/PWRITE          APB control
//   PADDR/PWDATA                 APB address / write data
//   PRDATA/PREADY                APB completer return
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;

  assign wait_nxt = wait_cnt + 8'd1;

  // Accept only in IDLE and never while reset is asserted, so nothing is
  // latched on an edge that reset is going to discard.
  assign cmd_ready = (state == IDLE) && !PRESET;
  assign busy      = (state != IDLE);

  // PADDR/PWRITE/PWDATA are the latched command registers themselves: they
  // change only on acceptance, so they stay stable through ACCESS wait
  // cycles and keep their last value while idle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= SETUP;
            PSEL   <= 1'b1;
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= 8'd0;
        end
        ACCESS: begin
          // PREADY is checked first so a completer answering on the very
          // edge the counter would expire still completes normally.
          if (PREADY) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end else if (wait_nxt == TIMEOUT_CNT) begin
            state     <= IDLE;
            wait_cnt  <= wait_nxt;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
//
// Purpose: drives directed commands and completer responses, checks APB
// signalling and responses against hand-computed values.
//
// Ports: none (top-level bench).
module tb_apb_master;

  logic       PCLK;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  logic       use_mem;
  logic [7:0] prdata_drv;
  logic [7:0] mem [0:255];

  int errors = 0;
  int checks = 0;
  int rsp_count;

  apb_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(4)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // 8-bit memory completer
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end
  assign PRDATA = use_mem ? mem[PADDR] : prdata_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h00;
    cmd_wdata  = 8'h00;
    PREADY     = 1'b1;
    use_mem    = 1'b1;
    prdata_drv = 8'h00;

    // reset state
    step();
    step();
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 8'h00);
    chk("rst_pwdata", PWDATA, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready_low", cmd_ready, 1'b0);
    PRESET = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1'b1);

    // zero-wait write 0x3C <- 0xA5
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h3C; cmd_wdata = 8'hA5;
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b101);
    chk("wr_setup_paddr", PADDR, 8'h3C);
    chk("wr_setup_pwdata", PWDATA, 8'hA5);
    chk("wr_setup_busy_ready", {busy, cmd_ready, rsp_valid}, 3'b100);
    step();
    chk("wr_access_ctl", {PSEL, PENABLE, PWRITE}, 3'b111);
    chk("wr_access_rsp", rsp_valid, 1'b0);
    step();
    chk("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h200);
    chk("wr_rsp_bus", {PSEL, PENABLE, busy, cmd_ready}, 4'b0001);
    chk("wr_idle_paddr_hold", PADDR, 8'h3C);
    step();
    chk("wr_rsp_one_cycle", rsp_valid, 1'b0);

    // zero-wait read 0x3C from the memory completer
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = 8'h00;
    step();
    cmd_valid = 1'b0;
    chk("rd_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b100);
    step();
    step();
    chk("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h2A5);

    // read with 3 wait cycles; ready lands on the edge the counter would hit TIMEOUT
    use_mem = 1'b0; PREADY = 1'b0; prdata_drv = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h77;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("wait_access%0d_ctl", i), {PSEL, PENABLE, rsp_valid}, 3'b110);
      chk($sformatf("wait_access%0d_paddr", i), PADDR, 8'h77);
      if (i == 3) begin
        PREADY = 1'b1;
        prdata_drv = 8'h5A;
      end
    end
    step();
    chk("wait_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h25A);
    PREADY = 1'b0; prdata_drv = 8'hFF;
    step();
    chk("wait_rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, 10'h05A);

    // timeout: PREADY never rises
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_access%0d", i), {PSEL, PENABLE, rsp_valid}, 3'b110);
    end
    step();
    chk("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
    chk("to_bus", {PSEL, PENABLE, busy}, 3'b000);
    step();
    chk("to_rsp_one_cycle", rsp_valid, 1'b0);

    // reset in the second ACCESS wait cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h11;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("rstmid_access2", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    step();
    chk("rstmid_bus", {PSEL, PENABLE, rsp_valid, busy, cmd_ready}, 5'b00000);
    PRESET = 1'b0;
    step();
    chk("rstmid_no_rsp", {rsp_valid, busy}, 2'b00);
    use_mem = 1'b1; PREADY = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h22;
    step();
    cmd_valid = 1'b0;
    chk("rstmid_wr_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 19'h5_2122);
    step();
    step();
    chk("rstmid_wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h200);

    // three back-to-back writes with cmd_valid held high
    step();
    rsp_count = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h01;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rsp_valid) rsp_count++;
      chk($sformatf("b2b_k%0d_rsp", k), rsp_valid, (k % 3 == 0 && k <= 9) ? 1'b1 : 1'b0);
      if (k % 3 == 0 && k <= 9) begin
        chk($sformatf("b2b_k%0d_order", k), {PADDR, PWDATA},
            {8'h40 + 8'(k / 3 - 1), 8'h01 + 8'(k / 3 - 1)});
      end
      if (k % 3 == 1) begin
        if (k < 7) begin
          cmd_addr  = 8'h40 + 8'(k / 3 + 1);
          cmd_wdata = 8'h01 + 8'(k / 3 + 1);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("b2b_rsp_count", rsp_count, 3);
    chk("b2b_mem", {mem[8'h40], mem[8'h41], mem[8'h42]}, 24'h010203);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
